// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Function : Round-robin single-port RAM arbiter (fetch / data) with data-side
//            lock for atomic RMW and a watchdog bounding fetch starvation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ack,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  lock_err
);

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int WD_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    // Last watchdog value seen while locked before the forced release.
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(LOCK_MAX - 2);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [WD_W-1:0]       r_wd;
    logic                  r_last_data;
    logic                  r_f_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_f_hold;
    logic [DATA_WIDTH-1:0] r_d_hold;
    logic                  r_lock_err;

    logic                  w_grant_f;
    logic                  w_grant_d;
    logic                  w_wd_expire;

    // Fetch only wins a tie when data was the previous grantee; never while locked.
    assign w_grant_f   = f_req & (r_state == ST_OPEN) & (~d_req | r_last_data);
    assign w_grant_d   = d_req & ~w_grant_f;
    assign w_wd_expire = (r_state == ST_LOCKED) && (r_wd == c_WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPEN;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_wd    <= (r_state == ST_LOCKED) ? r_wd + WD_W'(1) : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OPEN: begin
                if (w_grant_d && d_lock)
                    w_state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_wd_expire || (w_grant_d && !d_lock))
                    w_state_next = ST_OPEN;
            end
            default: w_state_next = ST_OPEN;
        endcase
    end

    always_comb begin
        f_ack     = w_grant_f;
        d_ack     = w_grant_d;
        ram_we    = w_grant_d & d_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_grant_f) begin
            ram_addr = f_addr;
        end else if (w_grant_d) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= 1'b1;
            r_lock_err  <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_f_hold    <= '0;
            r_d_hold    <= '0;
        end else begin
            if (w_wd_expire || w_grant_d)
                r_last_data <= 1'b1;
            else if (w_grant_f)
                r_last_data <= 1'b0;
            if (w_wd_expire)
                r_lock_err <= 1'b1;
            r_f_rvalid <= w_grant_f;
            r_d_rvalid <= w_grant_d & ~d_we;
            if (r_f_rvalid)
                r_f_hold <= ram_rdata;
            if (r_d_rvalid)
                r_d_hold <= ram_rdata;
        end
    end

    // Read data passes straight through on the valid cycle, then holds.
    assign f_rvalid = r_f_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign f_rdata  = r_f_rvalid ? ram_rdata : r_f_hold;
    assign d_rdata  = r_d_rvalid ? ram_rdata : r_d_hold;
    assign lock_err = r_lock_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Function : Self-checking bench for mem_arbiter with a behavioural RAM and
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_ack, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          lock_err;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM seen by the DUT.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 7) ^ 16'h5A5A);
    endfunction

    // Reference model state.
    logic [DW-1:0] ref_mem [0:65535];
    bit            m_locked, m_last_data, m_lock_err;
    int            m_lock_cycles;
    bit            exp_frv, exp_drv;
    logic [DW-1:0] exp_fdata, exp_ddata;

    // DUT outputs sampled during the last step, for directed checks.
    bit            s_fack, s_dack, s_ramwe, s_drv, s_lock_err;
    logic [DW-1:0] s_ddata, s_fdata;
    bit            l_gf, l_gd;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked      = 0;
        m_last_data   = 1;
        m_lock_err    = 0;
        m_lock_cycles = 0;
        exp_frv       = 0;
        exp_drv       = 0;
        exp_fdata     = '0;
        exp_ddata     = '0;
    endtask

    // Inputs are already applied (posedge+1); check mid-cycle, advance the model, move to next posedge+1.
    task automatic step();
        bit gf, gd;
        logic [AW-1:0] ea;
        #4;
        if (m_locked) begin
            gf = 0; gd = d_req;
        end else if (f_req && d_req) begin
            gf = m_last_data; gd = !m_last_data;
        end else begin
            gf = f_req; gd = d_req;
        end
        ea = gf ? f_addr : (gd ? d_addr : '0);
        check_eq("f_ack", f_ack, gf);
        check_eq("d_ack", d_ack, gd);
        check_eq("ram_we", ram_we, gd && d_we);
        check_eq("ram_addr", ram_addr, ea);
        if (gd && d_we) check_eq("ram_wdata", ram_wdata, d_wdata);
        check_eq("f_rvalid", f_rvalid, exp_frv);
        check_eq("d_rvalid", d_rvalid, exp_drv);
        check_eq("f_rdata", f_rdata, exp_fdata);
        check_eq("d_rdata", d_rdata, exp_ddata);
        check_eq("lock_err", lock_err, m_lock_err);
        s_fack = f_ack; s_dack = d_ack; s_ramwe = ram_we; s_drv = d_rvalid;
        s_ddata = d_rdata; s_fdata = f_rdata; s_lock_err = lock_err;
        l_gf = gf; l_gd = gd;

        exp_frv = gf;
        if (gf) exp_fdata = ref_mem[f_addr];
        exp_drv = gd && !d_we;
        if (exp_drv) exp_ddata = ref_mem[d_addr];
        if (gd && d_we) ref_mem[d_addr] = d_wdata;
        if (gd) m_last_data = 1;
        else if (gf) m_last_data = 0;
        if (!m_locked) begin
            if (gd && d_lock) begin
                m_locked = 1;
                m_lock_cycles = 0;
            end
        end else begin
            m_lock_cycles++;
            if (m_lock_cycles == LM - 1) begin
                m_locked = 0; m_lock_err = 1; m_last_data = 1;
            end else if (gd && !d_lock) begin
                m_locked = 0; m_last_data = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req = 0; d_req = 0; d_we = 0; d_lock = 0;
    endtask

    initial begin
        int n;
        bit seen;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_f_rvalid", f_rvalid, 0);
        check_eq("rst_lock_err", lock_err, 0);
        rst_n = 1;

        // Both ports contend: fetch wins first tie, then strict alternation.
        f_req = 1; f_addr = 16'h0040;
        d_req = 1; d_addr = 16'h0200; d_we = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("alt_f_ack", s_fack, (i % 2 == 0));
            check_eq("alt_d_ack", s_dack, (i % 2 == 1));
        end
        idle(); step(); step();

        // Lone fetch: same-cycle ack, data next cycle.
        f_req = 1; f_addr = 16'h0010;
        step();
        check_eq("t1_ack", s_fack, 1);
        f_req = 0;
        step();
        check_eq("t1_rdata", s_fdata, init_val(16'h0010));

        // Locked RMW with fetch pending throughout.
        f_req = 1; f_addr = 16'h0020;
        d_req = 1; d_we = 1; d_lock = 1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
        step();
        check_eq("t3_wr_ack", s_dack, 1);
        d_we = 0; d_lock = 0;
        step();
        check_eq("t3_no_fack", s_fack, 0);
        check_eq("t3_rd_ack", s_dack, 1);
        d_req = 0;
        step();
        check_eq("t3_fack_after", s_fack, 1);
        check_eq("t3_rdata", s_ddata, 16'hBEEF);
        idle(); step();

        // Watchdog: lock then abandon, fetch must resume LOCK_MAX cycles after the lock grant.
        f_req = 1; f_addr = 16'h0044;
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 16'h0005;
        step();
        check_eq("t4_lock_ack", s_dack, 1);
        d_req = 0; d_lock = 0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            seen = s_fack;
        end
        check_eq("t4_resume_cycle", n, LM);
        check_eq("t4_lock_err", s_lock_err, 1);
        idle();
        repeat (3) step();
        check_eq("t4_sticky", s_lock_err, 1);

        // Single write: one cycle of ram_we, no read valid.
        d_req = 1; d_we = 1; d_addr = 16'h0123; d_wdata = 16'h1234;
        step();
        check_eq("t6_we", s_ramwe, 1);
        idle();
        step();
        check_eq("t6_we_off", s_ramwe, 0);
        check_eq("t6_no_rvalid", s_drv, 0);

        // Reset right after a read ack drops the pending rvalid and clears lock_err.
        d_req = 1; d_we = 0; d_addr = 16'h0010;
        step();
        idle();
        rst_n = 0;
        #1;
        check_eq("t5_rvalid_drop", d_rvalid, 0);
        check_eq("t5_lock_err_clr", lock_err, 0);
        model_reset();
        step();
        rst_n = 1;
        step();
        check_eq("t5_no_rvalid", s_drv, 0);

        // Random traffic honouring the hold-until-ack protocol.
        for (int c = 0; c < 2000; c++) begin
            if (!(f_req && !l_gf)) begin
                f_req  = ($urandom_range(0, 1) == 1);
                f_addr = AW'($urandom_range(0, 63));
            end
            if (!(d_req && !l_gd)) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) == 1);
                d_lock  = ($urandom_range(0, 3) == 0);
                d_addr  = AW'($urandom_range(0, 63));
                d_wdata = DW'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
